// File: rtl/clk_en_gen.sv
// Multi-channel clock-enable generator.
// From one source clock it produces one single-cycle strobe and one divided square
// wave per channel. Each channel has its own divide ratio, which can be changed at
// runtime. Any accepted write to a real channel re-settles the block, so that all
// channels restart phase-aligned. locked_o reports when the outputs are valid.
`timescale 1ns/1ps

module clk_en_gen #(
    parameter int                        NUM_CH      = 3,
    parameter int                        DIV_W       = 8,
    parameter int                        LOCK_CYCLES = 16,
    parameter logic [NUM_CH*DIV_W-1:0]   DIV_INIT    = 24'h04_03_01,
    localparam int                       CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cfg_valid_i,
    output logic              cfg_ready_o,
    input  logic [CH_W-1:0]   cfg_ch_i,
    input  logic [DIV_W-1:0]  cfg_div_i,
    output logic [NUM_CH-1:0] clk_en_o,
    output logic [NUM_CH-1:0] clk_out_o,
    output logic              locked_o
);

    localparam int               SET_W    = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(LOCK_CYCLES - 1);

    typedef enum logic {
        ST_SETTLE = 1'b0,
        ST_RUN    = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [SET_W-1:0]  settle_q, settle_d;
    logic              locked_q, cfg_ready_q;
    logic [NUM_CH-1:0] clk_en_q, clk_out_q;
    logic [NUM_CH-1:0] en_d, out_d;
    logic              accept, ch_valid, cfg_hit, run_d;

    // cfg_ready_q is only ever high in RUN, so this is the whole handshake.
    assign accept   = cfg_valid_i & cfg_ready_q;
    // Out-of-range channel writes are consumed but must not disturb anything.
    assign ch_valid = (32'(cfg_ch_i) < NUM_CH);
    assign cfg_hit  = accept & ch_valid;

    // Next-state logic: SETTLE counts out the lock delay, RUN waits for a real write.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        case (state_q)
            ST_SETTLE: begin
                if (settle_q == SET_LAST) begin
                    state_d  = ST_RUN;
                    settle_d = '0;
                end else begin
                    settle_d = settle_q + SET_W'(1);
                end
            end
            ST_RUN: begin
                if (cfg_hit) begin
                    state_d  = ST_SETTLE;
                    settle_d = '0;
                end
            end
            default: begin
                state_d  = ST_SETTLE;
                settle_d = '0;
            end
        endcase
    end

    assign run_d = (state_d == ST_RUN);

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [DIV_W-1:0] div_q, div_d;
            logic [DIV_W-1:0] cnt_q, cnt_d;
            logic [DIV_W-1:0] d_eff, half;

            // A ratio of 0 behaves as 1; high phase lasts ceil(d/2) cycles.
            assign d_eff = (div_q == '0) ? DIV_W'(1) : div_q;
            assign half  = (d_eff >> 1) + DIV_W'(d_eff[0]);

            // Counter advances only while staying in RUN; entering RUN starts it at 0.
            always_comb begin
                div_d = div_q;
                if (cfg_hit && (cfg_ch_i == CH_W'(gi))) begin
                    div_d = cfg_div_i;
                end
                cnt_d = '0;
                if ((state_q == ST_RUN) && run_d) begin
                    cnt_d = (cnt_q >= d_eff - DIV_W'(1)) ? '0 : cnt_q + DIV_W'(1);
                end
            end

            // Outputs are decoded from the next count so the flops line up with cnt.
            assign en_d[gi]  = run_d && (cnt_d == '0);
            assign out_d[gi] = run_d && (cnt_d < half);

            // Per-channel ratio and phase counter.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    div_q <= DIV_INIT[gi*DIV_W +: DIV_W];
                    cnt_q <= '0;
                end else begin
                    div_q <= div_d;
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

    // FSM state plus all registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_SETTLE;
            settle_q    <= '0;
            locked_q    <= 1'b0;
            cfg_ready_q <= 1'b0;
            clk_en_q    <= '0;
            clk_out_q   <= '0;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            locked_q    <= run_d;
            cfg_ready_q <= run_d;
            clk_en_q    <= en_d;
            clk_out_q   <= out_d;
        end
    end

    assign cfg_ready_o = cfg_ready_q;
    assign locked_o    = locked_q;
    assign clk_en_o    = clk_en_q;
    assign clk_out_o   = clk_out_q;

endmodule
